// File: rtl/ext_bus_target_pkg.sv
// Shared definitions for the external-bus target: FSM state encoding, bus error data
// and the chip-select match helper.
package ext_bus_target_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } ExtTgtState_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

  // True when any active-low chip select is asserted in an area this target owns
  function automatic logic cs_hit(input logic [3:0] cs_n, input logic [3:0] mask);
    return |(~cs_n & mask);
  endfunction

endpackage

// File: rtl/ext_bus_target.sv
// SH-2 style external-bus responder bridging bus cycles to a req/ack backend.
// Optional build macro EXT_BUS_TGT_TIMEOUT_EN adds a CE_R-counted backend timeout.
module ext_bus_target
  import ext_bus_target_pkg::*;
#(
  parameter logic [3:0] CS_MASK = 4'b0001,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [26:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  input  logic        BS_N,
  input  logic        CS0_N,
  input  logic        CS1_N,
  input  logic        CS2_N,
  input  logic        CS3_N,
  input  logic        RD_WR_N,
  input  logic        RD_N,
  input  logic [3:0]  WE_N,
  output logic        WAIT_N,
  output logic [26:0] MEM_A,
  output logic [31:0] MEM_DO,
  output logic [3:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic [31:0] MEM_DI,
  input  logic        MEM_ACK,
  output logic        ERR
);

  ExtTgtState_t state_r, state_s;
  logic [31:0]  do_r, do_s;
  logic         wait_n_r, wait_n_s;
  logic [26:0]  mem_a_r, mem_a_s;
  logic [31:0]  mem_do_r, mem_do_s;
  logic [3:0]   mem_be_r, mem_be_s;
  logic         mem_we_r, mem_we_s;
  logic         mem_req_r, mem_req_s;
  logic         err_r, err_s;
  logic         abort_r, abort_s;
  logic         abort_now_s;
  logic         sel_s;
  logic         unused_s;

  assign sel_s = cs_hit({CS3_N, CS2_N, CS1_N, CS0_N}, CS_MASK);

`ifdef EXT_BUS_TGT_TIMEOUT_EN
  logic [7:0] tmo_cnt_r, tmo_cnt_s;
  logic       tmo_hit_s;

  assign tmo_hit_s = ((tmo_cnt_r + 8'd1) == TIMEOUT);
  // Decode is driven by RD_WR_N; the phase strobes below carry no extra information here
  assign unused_s  = &{1'b0, CE_F, RD_N};
`else
  assign unused_s  = &{1'b0, CE_F, RD_N, TIMEOUT, BUS_ERR_DATA};
`endif

  // Next-state and next-output decode for the bus cycle FSM
  always_comb begin
    state_s     = state_r;
    do_s        = do_r;
    wait_n_s    = wait_n_r;
    mem_a_s     = mem_a_r;
    mem_do_s    = mem_do_r;
    mem_be_s    = mem_be_r;
    mem_we_s    = mem_we_r;
    mem_req_s   = mem_req_r;
    err_s       = 1'b0;
    abort_s     = abort_r;
    abort_now_s = 1'b0;
`ifdef EXT_BUS_TGT_TIMEOUT_EN
    tmo_cnt_s   = tmo_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (CE_R && !BS_N && sel_s) begin
          mem_a_s   = A;
          mem_do_s  = DI;
          mem_we_s  = ~RD_WR_N;
          mem_be_s  = RD_WR_N ? 4'b1111 : ~WE_N;
          wait_n_s  = 1'b0;
          mem_req_s = 1'b1;
          abort_s   = 1'b0;
`ifdef EXT_BUS_TGT_TIMEOUT_EN
          tmo_cnt_s = 8'd0;
`endif
          state_s   = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // Master dropping its select mid-request means it gave up; finish backend quietly
        abort_now_s = abort_r | (CE_R & ~sel_s);
        abort_s     = abort_now_s;
        if (MEM_ACK) begin
          mem_req_s = 1'b0;
          if (abort_now_s) begin
            err_s    = 1'b1;
            wait_n_s = 1'b1;
            state_s  = IDLE;
          end else begin
            do_s    = mem_we_r ? do_r : MEM_DI;
            state_s = DONE;
          end
        end
`ifdef EXT_BUS_TGT_TIMEOUT_EN
        else if (CE_R && tmo_hit_s) begin
          mem_req_s = 1'b0;
          err_s     = 1'b1;
          if (abort_now_s) begin
            wait_n_s = 1'b1;
            state_s  = IDLE;
          end else begin
            do_s    = mem_we_r ? do_r : BUS_ERR_DATA;
            state_s = DONE;
          end
        end else if (CE_R) begin
          tmo_cnt_s = tmo_cnt_r + 8'd1;
        end
`endif
        else begin
          mem_req_s = 1'b1;
        end
      end
      DONE: begin
        if (CE_R) begin
          wait_n_s = 1'b1;
          state_s  = sel_s ? DONE : IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s   = IDLE;
        wait_n_s  = 1'b1;
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and registered output update
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= IDLE;
      do_r      <= 32'd0;
      wait_n_r  <= 1'b1;
      mem_a_r   <= 27'd0;
      mem_do_r  <= 32'd0;
      mem_be_r  <= 4'd0;
      mem_we_r  <= 1'b0;
      mem_req_r <= 1'b0;
      err_r     <= 1'b0;
      abort_r   <= 1'b0;
`ifdef EXT_BUS_TGT_TIMEOUT_EN
      tmo_cnt_r <= 8'd0;
`endif
    end else begin
      state_r   <= state_s;
      do_r      <= do_s;
      wait_n_r  <= wait_n_s;
      mem_a_r   <= mem_a_s;
      mem_do_r  <= mem_do_s;
      mem_be_r  <= mem_be_s;
      mem_we_r  <= mem_we_s;
      mem_req_r <= mem_req_s;
      err_r     <= err_s;
      abort_r   <= abort_s;
`ifdef EXT_BUS_TGT_TIMEOUT_EN
      tmo_cnt_r <= tmo_cnt_s;
`endif
    end
  end

  assign DO      = do_r;
  assign WAIT_N  = wait_n_r;
  assign MEM_A   = mem_a_r;
  assign MEM_DO  = mem_do_r;
  assign MEM_BE  = mem_be_r;
  assign MEM_WE  = mem_we_r;
  assign MEM_REQ = mem_req_r;
  assign ERR     = err_r;

endmodule

// File: tb/tb_ext_bus_target.sv
// Directed bench for ext_bus_target: table of bus cycles plus abort, reset and timeout sequences.
module tb_ext_bus_target;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE_R, CE_F;
  logic [26:0] A;
  logic [31:0] DI, DO;
  logic        BS_N;
  logic        CS0_N, CS1_N, CS2_N, CS3_N;
  logic        RD_WR_N, RD_N;
  logic [3:0]  WE_N;
  logic        WAIT_N;
  logic [26:0] MEM_A;
  logic [31:0] MEM_DO;
  logic [3:0]  MEM_BE;
  logic        MEM_WE, MEM_REQ;
  logic [31:0] MEM_DI;
  logic        MEM_ACK;
  logic        ERR;

  logic [3:0]  cs_n;
  logic [1:0]  ce_cnt = 2'd0;
  logic        tied, ack_drv;
  int          lat, ack_cnt;
  bit          acked;
  int          checks = 0;
  int          failures = 0;

  assign {CS3_N, CS2_N, CS1_N, CS0_N} = cs_n;
  assign CE_R    = (ce_cnt == 2'd0);
  assign CE_F    = (ce_cnt == 2'd2);
  assign MEM_ACK = tied ? MEM_REQ : ack_drv;

  ext_bus_target #(.CS_MASK(4'b0001), .TIMEOUT(8'd4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .A(A), .DI(DI), .DO(DO),
    .BS_N(BS_N), .CS0_N(CS0_N), .CS1_N(CS1_N), .CS2_N(CS2_N), .CS3_N(CS3_N),
    .RD_WR_N(RD_WR_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(WAIT_N),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
    .MEM_REQ(MEM_REQ), .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) ce_cnt <= ce_cnt + 2'd1;

  // Backend: acknowledge for one CLK once MEM_REQ has been seen high for lat negedges
  initial begin
    ack_drv = 1'b0; ack_cnt = 0; acked = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack_drv) ack_drv = 1'b0;
      else if (!MEM_REQ) begin ack_cnt = 0; acked = 1'b0; end
      else if (!tied && lat > 0 && !acked) begin
        ack_cnt++;
        if (ack_cnt == lat) begin ack_drv = 1'b1; acked = 1'b1; end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  cs_n;
    logic        wr;
    logic [26:0] a;
    logic [31:0] di;
    logic [3:0]  we_n;
    logic [31:0] mem_di;
    int          lat;
    logic        tied;
    logic        sel;
    logic [3:0]  be;
    logic [31:0] dout;
    int          waits;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Leave the bench at a negedge whose following posedge is a CE_R edge
  task automatic to_ce();
    @(negedge CLK);
    while (!CE_R) @(negedge CLK);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_do"},     DO,      32'd0);
    check({tag, "_wait_n"}, {31'd0, WAIT_N}, 32'd1);
    check({tag, "_req"},    {31'd0, MEM_REQ}, 32'd0);
    check({tag, "_we"},     {31'd0, MEM_WE}, 32'd0);
    check({tag, "_a"},      {5'd0, MEM_A}, 32'd0);
    check({tag, "_mdo"},    MEM_DO,  32'd0);
    check({tag, "_be"},     {28'd0, MEM_BE}, 32'd0);
    check({tag, "_err"},    {31'd0, ERR}, 32'd0);
  endtask

  task automatic start_cycle(input vec_t v);
    lat = v.lat; tied = v.tied; MEM_DI = v.mem_di;
    to_ce();
    A = v.a; DI = v.di; RD_WR_N = ~v.wr; RD_N = v.wr;
    WE_N = v.wr ? v.we_n : 4'hF;
    cs_n = v.cs_n; BS_N = 1'b0;
    @(negedge CLK);
    BS_N = 1'b1;
  endtask

  task automatic end_cycle();
    @(negedge CLK);
    cs_n = 4'hF; RD_N = 1'b1; WE_N = 4'hF;
    to_ce();
    to_ce();
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  nw;
    bit  done;
    string t;
    t = $sformatf("v%0d", idx);
    start_cycle(v);
    check({t, "_wait_lo"}, {31'd0, WAIT_N}, {31'd0, ~v.sel});
    check({t, "_req"}, {31'd0, MEM_REQ}, {31'd0, v.sel});
    if (v.sel) begin
      check({t, "_mem_a"}, {5'd0, MEM_A}, {5'd0, v.a});
      check({t, "_mem_do"}, MEM_DO, v.di);
      check({t, "_mem_be"}, {28'd0, MEM_BE}, {28'd0, v.be});
      check({t, "_mem_we"}, {31'd0, MEM_WE}, {31'd0, v.wr});
    end
    nw = 0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      to_ce();
      if (WAIT_N) done = 1'b1;
      else nw++;
    end
    check({t, "_released"}, {31'd0, done}, 32'd1);
    check({t, "_wait_samples"}, nw, v.waits);
    check({t, "_do"}, DO, v.dout);
    check({t, "_req_end"}, {31'd0, MEM_REQ}, 32'd0);
    end_cycle();
  endtask

  initial begin
    int errs, nce;
    bit fell;
    RST_N = 1'b0; BS_N = 1'b1; cs_n = 4'hF; A = 27'd0; DI = 32'd0;
    RD_WR_N = 1'b1; RD_N = 1'b1; WE_N = 4'hF; MEM_DI = 32'd0; tied = 1'b0; lat = 0;

    vecs[0] = '{4'b1110, 1'b0, 27'h0000040, 32'h0,        4'hF,    32'h12345678, 3, 1'b0, 1'b1, 4'hF,    32'h12345678, 1};
    vecs[1] = '{4'b1110, 1'b1, 27'h0000100, 32'hCAFEBABE, 4'b0011, 32'h0,        2, 1'b0, 1'b1, 4'b1100, 32'h12345678, 1};
    vecs[2] = '{4'b1011, 1'b0, 27'h0000200, 32'h0,        4'hF,    32'h77777777, 3, 1'b0, 1'b0, 4'hF,    32'h12345678, 0};
    vecs[3] = '{4'b1110, 1'b0, 27'h4000200, 32'h0,        4'hF,    32'hA5A50F0F, 0, 1'b1, 1'b1, 4'hF,    32'hA5A50F0F, 1};
    vecs[4] = '{4'b1110, 1'b0, 27'h0000204, 32'h0,        4'hF,    32'h0BADF00D, 0, 1'b1, 1'b1, 4'hF,    32'h0BADF00D, 1};
    vecs[5] = '{4'b1110, 1'b0, 27'h7FFFFFF, 32'h0,        4'hF,    32'hDEADBEEF, 6, 1'b0, 1'b1, 4'hF,    32'hDEADBEEF, 2};
    vecs[6] = '{4'b1110, 1'b1, 27'h0000003, 32'h11223344, 4'b1110, 32'h0,        4, 1'b0, 1'b1, 4'b0001, 32'hDEADBEEF, 2};

    repeat (3) @(negedge CLK);
    check_reset_vals("rst0");
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort: master drops CS0 right after BS_N; backend acks 10 CLK later
    start_cycle('{4'b1110, 1'b0, 27'h0000080, 32'h0, 4'hF, 32'h55AA55AA, 10, 1'b0, 1'b1, 4'hF, 32'h0, 0});
    cs_n = 4'hF; RD_N = 1'b1;
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (ERR) errs++;
    end
    check("abort_err_pulses", errs, 1);
    check("abort_do_kept", DO, 32'hDEADBEEF);
    check("abort_wait_n", {31'd0, WAIT_N}, 32'd1);
    check("abort_req", {31'd0, MEM_REQ}, 32'd0);
    run_vec(10, vecs[3]);

`ifdef EXT_BUS_TGT_TIMEOUT_EN
    // Timeout: no backend ACK at all
    start_cycle('{4'b1110, 1'b0, 27'h0000300, 32'h0, 4'hF, 32'h0, 0, 1'b0, 1'b1, 4'hF, 32'h0, 0});
    errs = 0; nce = 0; fell = 1'b0;
    for (int k = 0; k < 100 && !fell; k++) begin
      @(negedge CLK);
      if (ERR) errs++;
      if (!MEM_REQ) fell = 1'b1;
      else if (CE_R) nce++;
    end
    check("tmo_req_fell", {31'd0, fell}, 32'd1);
    check("tmo_ce_edges", nce, 4);
    check("tmo_err", errs, 1);
    check("tmo_do", DO, 32'hFFFFFFFF);
    check("tmo_wait_still_lo", {31'd0, WAIT_N}, 32'd0);
    to_ce();
    @(posedge CLK); #1;
    check("tmo_wait_hi", {31'd0, WAIT_N}, 32'd1);
    end_cycle();
`endif

    // Reset mid-REQ: write with a backend that never answers
    start_cycle('{4'b1110, 1'b1, 27'h0000555, 32'h87654321, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 4'hF, 32'h0, 0});
    check("rst_mid_req_before", {31'd0, MEM_REQ}, 32'd1);
    RST_N = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge CLK);
    RST_N = 1'b1;
    end_cycle();
    run_vec(11, vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
